// File: rtl/jesd204b_tpl_mapper_if.sv
// -----------------------------------------------------------------------------
// jesd204b_tpl_mapper_if
// Frame-level stream bundle for the JESD204B transport-layer mapper.
//   Input side : tx_datain  (S*M*N bits, sample k at [k*N +: N])
//                tx_ctrlin  (max(S*M*CS,1) bits, sample k at [k*CS +: CS])
//                in_valid / in_ready handshake
//   Output side: tx_dataout (S*M*N' bits, lane i word at [i*8*F +: 8*F])
//                out_valid / out_ready handshake
//                out_somf / out_eomf multiframe markers
// The master modport is the frame source/sink (test or upstream logic);
// the slave modport is the mapper itself.
// -----------------------------------------------------------------------------
interface jesd204b_tpl_mapper_if #(
   parameter int CONVERTERS  = 8,
   parameter int RESOLUTION  = 11,
   parameter int CONTROL     = 2,
   parameter int SAMPLE_SIZE = 16,
   parameter int SAMPLES     = 1
);
   localparam int NS     = SAMPLES * CONVERTERS;
   localparam int DIN_W  = NS * RESOLUTION;
   localparam int CIN_W  = (NS * CONTROL > 0) ? NS * CONTROL : 1;
   localparam int DOUT_W = NS * SAMPLE_SIZE;

   logic [DIN_W-1:0]  tx_datain;
   logic [CIN_W-1:0]  tx_ctrlin;
   logic              in_valid;
   logic              in_ready;
   logic [DOUT_W-1:0] tx_dataout;
   logic              out_valid;
   logic              out_ready;
   logic              out_somf;
   logic              out_eomf;

   modport master (
      output tx_datain, tx_ctrlin, in_valid, out_ready,
      input  in_ready, tx_dataout, out_valid, out_somf, out_eomf
   );

   modport slave (
      input  tx_datain, tx_ctrlin, in_valid, out_ready,
      output in_ready, tx_dataout, out_valid, out_somf, out_eomf
   );
endinterface

// File: rtl/jesd204b_tpl_mapper.sv
// -----------------------------------------------------------------------------
// jesd204b_tpl_mapper
// JESD204B transmit transport layer: packs one frame of converter samples
// (data + control + tail) into per-lane octet words, one frame per cycle,
// through a single output register stage with valid/ready backpressure.
//
// Ports
//   clk      : clock
//   rst      : synchronous, active-high reset
//   link_en  : mapper enable; low drops the held word and restarts the
//              multiframe count
//   bus      : jesd204b_tpl_mapper_if.slave (input frame, output lane words,
//              handshakes, start/end-of-multiframe markers)
//
// Build option
//   TPL_TAIL_PRBS_EN : when defined, tail bits carry lfsr[T-1:0] of a
//                      15-bit x^15+x^14+1 LFSR stepped once per accepted
//                      frame; otherwise tail bits are zero.
//
// Sample word layout, MSB first: {data[N-1:0], ctrl[CS-1:0], tail[T-1:0]}.
// Sample k goes to lane k/(M*S/L), slot k%(M*S/L); slot 0 is the MSB slot.
// -----------------------------------------------------------------------------
module jesd204b_tpl_mapper #(
   parameter int LANES         = 4,
   parameter int CONVERTERS    = 8,
   parameter int RESOLUTION    = 11,
   parameter int CONTROL       = 2,
   parameter int SAMPLE_SIZE   = 16,
   parameter int SAMPLES       = 1,
   parameter int FRAMES_PER_MF = 32
) (
   input logic                  clk,
   input logic                  rst,
   input logic                  link_en,
   jesd204b_tpl_mapper_if.slave bus
);
   localparam int NS     = SAMPLES * CONVERTERS;
   localparam int SPL    = NS / LANES;                 // sample slots per lane
   localparam int T      = SAMPLE_SIZE - RESOLUTION - CONTROL;
   localparam int TW     = (T > 0) ? T : 1;
   localparam int DOUT_W = NS * SAMPLE_SIZE;
   localparam int FW     = (FRAMES_PER_MF > 1) ? $clog2(FRAMES_PER_MF) : 1;
   localparam logic [FW-1:0] FLAST = FW'(FRAMES_PER_MF - 1);

   logic [DOUT_W-1:0] mapped;
   logic [DOUT_W-1:0] dout;
   logic              ov;
   logic              somf;
   logic              eomf;
   logic              accept;
   logic [FW-1:0]     fcnt;
   logic [TW-1:0]     tail;

   // Ready depends on the registered valid and the downstream ready, so a
   // drain and a new accept can share a cycle (one frame per cycle).
   assign bus.in_ready = link_en && !rst && (!ov || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

`ifdef TPL_TAIL_PRBS_EN
   // Tail width is assumed <= 15 so the tail fits in the LFSR state.
   logic [14:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst)
         lfsr <= 15'h7FFF;
      else if (accept)
         lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
   end

   assign tail = lfsr[TW-1:0];
`else
   assign tail = '0;
`endif

   for (genvar k = 0; k < NS; k++) begin : g_smp
      // Lane base plus slot offset counted down from the lane MSB.
      localparam int POS = (k / SPL) * SPL * SAMPLE_SIZE
                         + (SPL - 1 - (k % SPL)) * SAMPLE_SIZE;
      logic [RESOLUTION+CONTROL-1:0] head;

      if (CONTROL > 0) begin : g_cs
         assign head = {bus.tx_datain[k*RESOLUTION +: RESOLUTION],
                        bus.tx_ctrlin[k*CONTROL +: CONTROL]};
      end else begin : g_nocs
         assign head = bus.tx_datain[k*RESOLUTION +: RESOLUTION];
      end

      if (T > 0) begin : g_tail
         assign mapped[POS +: SAMPLE_SIZE] = {head, tail};
      end else begin : g_notail
         assign mapped[POS +: SAMPLE_SIZE] = head;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout <= '0;
         ov   <= 1'b0;
         somf <= 1'b0;
         eomf <= 1'b0;
         fcnt <= '0;
      end else if (!link_en) begin
         ov   <= 1'b0;
         somf <= 1'b0;
         eomf <= 1'b0;
         fcnt <= '0;
      end else if (accept) begin
         dout <= mapped;
         ov   <= 1'b1;
         somf <= (fcnt == '0);
         eomf <= (fcnt == FLAST);
         fcnt <= (fcnt == FLAST) ? '0 : fcnt + 1'b1;
      end else if (bus.out_ready) begin
         ov <= 1'b0;
      end
   end

   assign bus.tx_dataout = dout;
   assign bus.out_valid  = ov;
   assign bus.out_somf   = somf;
   assign bus.out_eomf   = eomf;
endmodule
